// File: rtl/alu_seq_if.sv
// Issue/result bundle between the control unit, the ALU and the writeback stage.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_seq_if #(
  parameter int BUS = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [BUS-1:0] OPA;
  logic [BUS-1:0] OPB;
  logic [1:0]     FUNTYPE;
  logic [1:0]     FUNCODE;
  logic [BUS-1:0] result;
  logic [BUS-1:0] result_hi;
  logic [BUS-1:0] operandB;
  logic [3:0]     CPSR;
  logic           out_valid;

  modport master (
    output in_valid, OPA, OPB, FUNTYPE, FUNCODE,
    input  in_ready, result, result_hi, operandB, CPSR, out_valid
  );

  modport slave (
    input  in_valid, OPA, OPB, FUNTYPE, FUNCODE,
    output in_ready, result, result_hi, operandB, CPSR, out_valid
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle add/sub/logic/shift, iterative unsigned
// multiply (shift-add) and divide (restoring), CPSR flags {V,C,N,Z}.
module alu_seq #(
  parameter int BUS  = 8,
  parameter int CNTW = $clog2(BUS + 1)
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [BUS-1:0]  acc_hi;     // product high half / partial remainder
  logic [BUS-1:0]  acc_lo;     // multiplier -> product low half / dividend -> quotient
  logic [BUS-1:0]  opnd;       // multiplicand / divisor
  logic [CNTW-1:0] cnt;
  logic            is_div;

  logic [BUS-1:0]  result_q, result_hi_q, operand_b_q;
  logic [3:0]      cpsr_q;
  logic            out_valid_q;

  logic            accept;
  logic            start_iter;
  logic [CNTW-1:0] s;

  assign bus.in_ready  = (state == IDLE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.operandB  = operand_b_q;
  assign bus.CPSR      = cpsr_q;
  assign bus.out_valid = out_valid_q;

  assign accept     = bus.in_valid && (state == IDLE);
  assign start_iter = (bus.FUNTYPE == 2'b10) && !bus.FUNCODE[1];
  assign s          = bus.OPB[CNTW-1:0];

  // Single-cycle datapath: result, carry and overflow for classes 00/01 and reserved ops.
  logic [BUS-1:0]  sc_res;
  logic            sc_c, sc_v;
  logic [BUS:0]    wide;
  logic signed [BUS:0] swide;
  logic [CNTW-1:0] rot;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    wide   = '0;
    swide  = '0;
    rot    = '0;
    case ({bus.FUNTYPE, bus.FUNCODE})
      4'b0000: begin // ADD
        wide   = {1'b0, bus.OPA} + {1'b0, bus.OPB};
        sc_res = wide[BUS-1:0];
        sc_c   = wide[BUS];
        sc_v   = (bus.OPA[BUS-1] == bus.OPB[BUS-1]) && (sc_res[BUS-1] != bus.OPA[BUS-1]);
      end
      4'b0001: begin // SUB: carry is NOT borrow
        wide   = {1'b0, bus.OPA} - {1'b0, bus.OPB};
        sc_res = wide[BUS-1:0];
        sc_c   = ~wide[BUS];
        sc_v   = (bus.OPA[BUS-1] != bus.OPB[BUS-1]) && (sc_res[BUS-1] != bus.OPA[BUS-1]);
      end
      4'b0010: sc_res = bus.OPA & bus.OPB;
      4'b0011: sc_res = bus.OPA | bus.OPB;
      4'b0100: begin // LSL: the extra top bit catches the last bit shifted out
        wide   = {1'b0, bus.OPA} << s;
        sc_res = wide[BUS-1:0];
        sc_c   = wide[BUS];
      end
      4'b0101: begin // LSR: the extra bottom bit catches the last bit shifted out
        wide   = {bus.OPA, 1'b0} >> s;
        sc_res = wide[BUS:1];
        sc_c   = wide[0];
      end
      4'b0110: begin // ASR: saturates to sign copies for s >= BUS
        swide  = $signed({bus.OPA, 1'b0}) >>> s;
        sc_res = swide[BUS:1];
        sc_c   = swide[0];
      end
      4'b0111: begin // ROR by s mod BUS; carry is the new MSB
        rot    = CNTW'(int'(s) % BUS);
        sc_res = (bus.OPA >> rot) | (bus.OPA << (CNTW'(BUS) - rot));
        sc_c   = (s != '0) ? sc_res[BUS-1] : 1'b0;
      end
      default: ; // reserved ops: zero result, Z=1 via the flag logic
    endcase
  end

  // One multiply or divide iteration computed from the current accumulators.
  logic [BUS:0]   add_sum, shl, sub_diff;
  logic [BUS-1:0] nxt_hi, nxt_lo;

  always_comb begin
    add_sum  = {1'b0, acc_hi} + {1'b0, opnd};
    shl      = {acc_hi, acc_lo[BUS-1]};
    sub_diff = shl - {1'b0, opnd};
    if (is_div) begin
      // Remainder never exceeds the divisor, so bit BUS of the difference is the borrow.
      if (!sub_diff[BUS]) begin
        nxt_hi = sub_diff[BUS-1:0];
        nxt_lo = {acc_lo[BUS-2:0], 1'b1};
      end else begin
        nxt_hi = shl[BUS-1:0];
        nxt_lo = {acc_lo[BUS-2:0], 1'b0};
      end
    end else if (acc_lo[0]) begin
      {nxt_hi, nxt_lo} = {add_sum, acc_lo[BUS-1:1]};
    end else begin
      {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[BUS-1:1]};
    end
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state       <= IDLE;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd        <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      operand_b_q <= '0;
      cpsr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            operand_b_q <= bus.OPB;
            if (start_iter) begin
              state  <= BUSY;
              is_div <= bus.FUNCODE[0];
              cnt    <= '0;
              acc_hi <= '0;
              acc_lo <= bus.FUNCODE[0] ? bus.OPA : bus.OPB;
              opnd   <= bus.FUNCODE[0] ? bus.OPB : bus.OPA;
            end else begin
              result_q    <= sc_res;
              result_hi_q <= '0;
              cpsr_q      <= {sc_v, sc_c, sc_res[BUS-1], (sc_res == '0)};
              out_valid_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNTW'(BUS - 1)) begin
            state       <= IDLE;
            result_q    <= nxt_lo;
            result_hi_q <= nxt_hi;
            cpsr_q      <= {is_div && (opnd == '0), !is_div && (nxt_hi != '0),
                            nxt_lo[BUS-1], (nxt_lo == '0)};
            out_valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at BUS=8 with hand-computed expected values.
module tb_alu_seq;
  localparam int BUS = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   busy_bad;

  alu_seq_if #(.BUS(BUS)) bus ();

  alu_seq #(.BUS(BUS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request; called just after a falling edge.
  task automatic drive(input logic [1:0] ft, input logic [1:0] fc,
                       input logic [7:0] a, input logic [7:0] b);
    bus.FUNTYPE  = ft;
    bus.FUNCODE  = fc;
    bus.OPA      = a;
    bus.OPB      = b;
    bus.in_valid = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] res, input logic [7:0] hi,
                         input logic [3:0] cpsr);
    check({tag, ".valid"}, 16'(bus.out_valid), 16'd1);
    check({tag, ".result"}, 16'(bus.result), 16'(res));
    check({tag, ".result_hi"}, 16'(bus.result_hi), 16'(hi));
    check({tag, ".cpsr"}, 16'(bus.CPSR), 16'(cpsr));
  endtask

  // Issue a multi-cycle op; expect BUS busy cycles, then one result cycle.
  task automatic iter_op(input string tag, input logic [1:0] fc, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] res, input logic [7:0] hi,
                         input logic [3:0] cpsr, input bit inject);
    busy_bad = 0;
    drive(2'b10, fc, a, b);
    for (int k = 0; k < BUS; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_bad++;
      if (inject && k == 2) drive(2'b00, 2'b00, 8'h01, 8'h01);
    end
    check({tag, ".busy"}, 16'(busy_bad), 16'd0);
    @(negedge clk);
    chk_out(tag, res, hi, cpsr);
    check({tag, ".operandB"}, 16'(bus.operandB), 16'(b));
    @(negedge clk);
    check({tag, ".pulse"}, 16'(bus.out_valid), 16'd0);
    check({tag, ".ready"}, 16'(bus.in_ready), 16'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid = 1'b0;
    bus.OPA      = '0;
    bus.OPB      = '0;
    bus.FUNTYPE  = '0;
    bus.FUNCODE  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.result", 16'(bus.result), 16'h0);
    check("rst.result_hi", 16'(bus.result_hi), 16'h0);
    check("rst.cpsr", 16'(bus.CPSR), 16'h0);
    check("rst.out_valid", 16'(bus.out_valid), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst.in_ready", 16'(bus.in_ready), 16'h1);

    // ADD 2+1, then 0xFF+1
    drive(2'b00, 2'b00, 8'h02, 8'h01);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("add1", 8'h03, 8'h00, 4'b0000);
    check("add1.operandB", 16'(bus.operandB), 16'h01);
    @(negedge clk);
    check("add1.pulse", 16'(bus.out_valid), 16'h0);
    drive(2'b00, 2'b00, 8'hFF, 8'h01);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("add2", 8'h00, 8'h00, 4'b0101);

    // Three SUBs back-to-back
    drive(2'b00, 2'b01, 8'h03, 8'h01);
    @(negedge clk);
    check("sub1.ready", 16'(bus.in_ready), 16'h1);
    chk_out("sub1", 8'h02, 8'h00, 4'b0100);
    drive(2'b00, 2'b01, 8'h03, 8'h03);
    @(negedge clk);
    check("sub2.ready", 16'(bus.in_ready), 16'h1);
    chk_out("sub2", 8'h00, 8'h00, 4'b0101);
    drive(2'b00, 2'b01, 8'h00, 8'h01);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("sub3", 8'hFF, 8'h00, 4'b0010);
    @(negedge clk);
    check("sub3.pulse", 16'(bus.out_valid), 16'h0);

    // Logic ops
    drive(2'b00, 2'b10, 8'hF0, 8'h3C);
    @(negedge clk);
    chk_out("and", 8'h30, 8'h00, 4'b0000);
    drive(2'b00, 2'b11, 8'h80, 8'h01);
    @(negedge clk);
    chk_out("or", 8'h81, 8'h00, 4'b0010);

    // Shifts, including amounts >= BUS
    drive(2'b01, 2'b10, 8'h80, 8'h03);
    @(negedge clk);
    chk_out("asr", 8'hF0, 8'h00, 4'b0010);
    drive(2'b01, 2'b01, 8'h81, 8'h01);
    @(negedge clk);
    chk_out("lsr", 8'h40, 8'h00, 4'b0100);
    drive(2'b01, 2'b11, 8'h01, 8'h09);
    @(negedge clk);
    chk_out("ror9", 8'h80, 8'h00, 4'b0110);
    drive(2'b01, 2'b00, 8'h01, 8'h08);
    @(negedge clk);
    chk_out("lsl8", 8'h00, 8'h00, 4'b0101);
    drive(2'b01, 2'b10, 8'h85, 8'h0A);
    @(negedge clk);
    chk_out("asr10", 8'hFF, 8'h00, 4'b0110);
    drive(2'b01, 2'b01, 8'hFF, 8'h09);
    @(negedge clk);
    chk_out("lsr9", 8'h00, 8'h00, 4'b0001);

    // Reserved op
    drive(2'b11, 2'b00, 8'h12, 8'h34);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("rsvd", 8'h00, 8'h00, 4'b0001);
    check("rsvd.operandB", 16'(bus.operandB), 16'h34);
    @(negedge clk);

    // Iterative multiply/divide
    iter_op("mul1", 2'b00, 8'h0F, 8'h11, 8'hFF, 8'h00, 4'b0010, 1'b1);
    iter_op("mul2", 2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0100, 1'b0);
    iter_op("div1", 2'b01, 8'd100, 8'd7, 8'h0E, 8'h02, 4'b0000, 1'b0);
    iter_op("div0", 2'b01, 8'h55, 8'h00, 8'hFF, 8'h55, 4'b1010, 1'b0);

    // Reset four cycles into a multiply
    drive(2'b10, 2'b00, 8'h0F, 8'h11);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.valid", 16'(bus.out_valid), 16'h0);
    check("abort.result", 16'(bus.result), 16'h0);
    check("abort.result_hi", 16'(bus.result_hi), 16'h0);
    check("abort.operandB", 16'(bus.operandB), 16'h0);
    check("abort.cpsr", 16'(bus.CPSR), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check("abort.ready", 16'(bus.in_ready), 16'h1);
    busy_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) busy_bad++;
    end
    check("abort.no_valid", 16'(busy_bad), 16'h0);
    drive(2'b00, 2'b00, 8'h05, 8'h06);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_out("post_rst_add", 8'h0B, 8'h00, 4'b0000);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
